// File: rtl/addr_tx_state_machine_if.sv
// Handshake/serial bundle between the address serializer (master) and its
// consumer, which drives start/addr_in/ready.
interface addr_tx_state_machine_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  ready;
  logic                  valid;
  logic                  tx_address;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, addr_in, ready,
    output valid, tx_address, busy, done
  );

  modport slave (
    output start, addr_in, ready,
    input  valid, tx_address, busy, done
  );
endinterface

// File: rtl/addr_tx_state_machine.sv
// Master-side address serializer: latches an address on start, offers it with
// valid, then shifts it out MSB-first one bit per clock after the handshake.
module addr_tx_state_machine #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  addr_tx_state_machine_if.master bus
);
  localparam int CNT_W = $clog2(ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, WAIT_HS, SHIFT, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  valid, tx_address, busy, done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  // Outputs decode only registered state, so start/ready never reach them
  // combinationally.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    valid      = 1'b0;
    tx_address = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          shreg_next = bus.addr_in;
          cnt_next   = '0;
          state_next = WAIT_HS;
        end
      end
      WAIT_HS: begin
        valid      = 1'b1;
        tx_address = shreg[ADDR_WIDTH-1];
        if (bus.ready) begin
          shreg_next = {shreg[ADDR_WIDTH-2:0], 1'b0};
          cnt_next   = CNT_W'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        tx_address = shreg[ADDR_WIDTH-1];
        shreg_next = {shreg[ADDR_WIDTH-2:0], 1'b0};
        // Counter holds at its final value instead of wrapping.
        if (cnt == CNT_W'(ADDR_WIDTH - 1)) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.valid      = valid;
  assign bus.tx_address = tx_address;
  assign bus.busy       = busy;
  assign bus.done       = done;
endmodule

// File: tb/tb_addr_tx_state_machine.sv
// Directed bench for addr_tx_state_machine: hand-derived bit streams,
// handshake stalls, reset mid-frame and back-to-back framing.
`timescale 1ns/1ps
module tb_addr_tx_state_machine;
  localparam int W = 12;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  addr_tx_state_machine_if #(.ADDR_WIDTH(W)) bus_if ();

  addr_tx_state_machine #(.ADDR_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame from an IDLE cycle; ends in the IDLE cycle after DONE.
  task automatic send(input logic [W-1:0] addr, input int stall, input bit tog,
                      input bit restart, input string tag,
                      output int msb_cyc, output int lsb_cyc);
    logic [W-1:0] rx;
    logic [W-1:0] exp_bits;
    exp_bits = addr;
    rx       = '0;
    bus_if.start   = 1'b1;
    bus_if.addr_in = addr;
    bus_if.ready   = (stall == 0);
    tick();
    bus_if.start = restart;
    if (restart) bus_if.addr_in = '0;
    msb_cyc = cyc;
    for (int i = 0; i <= stall; i++) begin
      check({tag, "_hs_valid"}, bus_if.valid, 1);
      check({tag, "_hs_tx"}, bus_if.tx_address, exp_bits[W-1]);
      check({tag, "_hs_busy"}, bus_if.busy, 1);
      if (i == stall) rx = {rx[W-2:0], bus_if.tx_address};
      bus_if.ready = (i == stall);
      tick();
    end
    lsb_cyc = cyc;
    for (int b = W - 2; b >= 0; b--) begin
      check({tag, "_sh_valid"}, bus_if.valid, 0);
      check({tag, "_sh_tx"}, bus_if.tx_address, exp_bits[b]);
      rx = {rx[W-2:0], bus_if.tx_address};
      lsb_cyc = cyc;
      if (tog) bus_if.ready = ~bus_if.ready;
      if (restart) bus_if.start = (b > 1);
      tick();
    end
    bus_if.start = 1'b0;
    check({tag, "_done"}, bus_if.done, 1);
    check({tag, "_done_tx"}, bus_if.tx_address, 0);
    check({tag, "_done_busy"}, bus_if.busy, 1);
    check({tag, "_done_valid"}, bus_if.valid, 0);
    check({tag, "_rx_word"}, rx, addr);
    tick();
    check({tag, "_idle_busy"}, bus_if.busy, 0);
    check({tag, "_idle_done"}, bus_if.done, 0);
    check({tag, "_idle_valid"}, bus_if.valid, 0);
  endtask

  initial begin
    int m0, l0, m1, l1;
    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    bus_if.start   = 1'b0;
    bus_if.addr_in = '0;
    bus_if.ready   = 1'b0;
    #1;
    check("rst_valid", bus_if.valid, 0);
    check("rst_tx", bus_if.tx_address, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_done", bus_if.done, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset mid-SHIFT while bit 5 of an all-ones word is on the line.
    bus_if.start   = 1'b1;
    bus_if.addr_in = 12'hFFF;
    bus_if.ready   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_tx_before_rst", bus_if.tx_address, 1);
    check("mid_busy_before_rst", bus_if.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", bus_if.valid, 0);
    check("mid_rst_tx", bus_if.tx_address, 0);
    check("mid_rst_busy", bus_if.busy, 0);
    check("mid_rst_done", bus_if.done, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_busy", bus_if.busy, 0);
      check("idle_ready_valid", bus_if.valid, 0);
    end
    bus_if.ready = 1'b0;

    send(12'hA5B, 0, 1'b0, 1'b0, "a5b", m0, l0);
    send(12'hFFF, 7, 1'b0, 1'b0, "fff_stall", m0, l0);
    send(12'h801, 0, 1'b0, 1'b1, "restart", m0, l0);
    tick();
    check("restart_ignored_busy", bus_if.busy, 0);

    // Back-to-back: second start issued in the IDLE cycle after DONE.
    send(12'h3C7, 0, 1'b0, 1'b0, "b2b0", m0, l0);
    send(12'h124, 0, 1'b0, 1'b0, "b2b1", m1, l1);
    check("b2b_gap", m1 - l0, 3);
    check("b2b_period", m1 - m0, W + 2);

    send(12'h5A6, 0, 1'b1, 1'b0, "ready_toggle", m0, l0);
    check("frame_len", l0 - m0, W - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
